// File: rtl/georgios_pkg.sv
// Shared opcode constants, immediate-byte classification and FSM state type
// for the instr_issue fetch/issue front end.
package georgios_pkg;

  localparam logic [2:0] OP_HALT = 3'd0;
  localparam logic [2:0] OP_NOP  = 3'd1;
  localparam logic [2:0] OP_SET  = 3'd2;
  localparam logic [2:0] OP_COPY = 3'd3;
  localparam logic [2:0] OP_ADDR = 3'd4;
  localparam logic [2:0] OP_ADDV = 3'd5;
  localparam logic [2:0] OP_SUBR = 3'd6;
  localparam logic [2:0] OP_SUBV = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    ISSUE,
    HALTED
  } state_e;

  // Ops carrying a second (immediate) byte in program memory.
  function automatic logic needs_imm(input logic [2:0] op);
    return (op == OP_SET) || (op == OP_ADDV) || (op == OP_SUBV);
  endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter: ADDR_W bits wide, synchronous reset to 0, increments by one
// when inc_i is set and wraps silently from all-ones back to zero.
module prog_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc_i) pc_d = pc_q + ADDR_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_issue.sv
// Fetch/issue front end: reads op and optional immediate bytes from program
// memory and hands {op, ra, rb, imm} to the decoder. Optional ISSUE_COUNT_EN.
module instr_issue
  import georgios_pkg::*;
#(
  parameter int W      = 8,
  parameter int OP_W   = 3,
  parameter int REG_W  = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [W-1:0]      mem_data,
  input  logic              mem_valid,
  output logic [OP_W-1:0]   op,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [W-1:0]      imm,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              halted
`ifdef ISSUE_COUNT_EN
  ,
  output logic [15:0]       issued_count
`endif
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [REG_W-1:0]  ra_q, rb_q;
  logic [W-1:0]      imm_q;
  logic [OP_W-1:0]   op_field;
  logic [REG_W-1:0]  ra_field, rb_field;
  logic              in_fetch, in_fetch_imm, byte_taken, handshake;

  assign op_field = mem_data[W-1 -: OP_W];
  assign ra_field = mem_data[W-1-OP_W -: REG_W];
  assign rb_field = mem_data[W-1-OP_W-REG_W -: REG_W];

  assign in_fetch     = (state_q == FETCH);
  assign in_fetch_imm = (state_q == FETCH_IMM);
  // mem_valid only counts while a read is outstanding; strays are dropped here.
  assign byte_taken   = mem_valid && (in_fetch || in_fetch_imm);
  assign handshake    = op_valid && op_ready;

  prog_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clock (clock),
    .reset (reset),
    .inc_i (byte_taken),
    .pc_o  (mem_addr)
  );

  // NOTE: next-state defaults to the current state first, so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = FETCH;
      FETCH:     if (mem_valid) state_d = needs_imm(3'(op_field)) ? FETCH_IMM : ISSUE;
      FETCH_IMM: if (mem_valid) state_d = ISSUE;
      ISSUE:     if (handshake) state_d = (op_q == OP_W'(OP_HALT)) ? HALTED : FETCH;
      HALTED:    state_d = HALTED;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: reset clears the issue fields too, so the decoder never sees stale bytes after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_fetch && mem_valid) begin
        op_q  <= op_field;
        ra_q  <= ra_field;
        rb_q  <= rb_field;
        imm_q <= '0;
      end
      if (in_fetch_imm && mem_valid) imm_q <= mem_data;
    end
  end

  assign mem_rd   = in_fetch || in_fetch_imm;
  assign op_valid = (state_q == ISSUE);
  assign halted   = (state_q == HALTED);
  assign op       = op_q;
  assign ra       = ra_q;
  assign rb       = rb_q;
  assign imm      = imm_q;

`ifdef ISSUE_COUNT_EN
  logic [15:0] issued_count_q;

  always_ff @(posedge clock) begin
    if (reset) issued_count_q <= '0;
    else if (handshake && (issued_count_q != 16'hFFFF)) issued_count_q <= issued_count_q + 16'd1;
  end

  assign issued_count = issued_count_q;
`endif

endmodule

// File: tb/tb_instr_issue.sv
// Directed self-checking bench for instr_issue (ADDR_W=4) with a behavioural
// program-memory responder of programmable latency.
module tb_instr_issue;

  localparam int W = 8, OP_W = 3, REG_W = 2, ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [W-1:0]      mem_data = '0;
  logic              mem_valid = 1'b0;
  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  ra, rb;
  logic [W-1:0]      imm;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic              halted;
`ifdef ISSUE_COUNT_EN
  logic [15:0]       issued_count;
`endif

  logic [W-1:0] mem [16];
  int           lat = 0;
  int           wait_cnt = 0;
  logic         stray_req = 1'b0;
  int           n_assert = 0;
  int           n_fail = 0;
  logic         found;

  instr_issue #(.W(W), .OP_W(OP_W), .REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .imm       (imm),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .halted    (halted)
`ifdef ISSUE_COUNT_EN
    ,
    .issued_count (issued_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory responder: answers a held read after 'lat' extra cycles with a one-cycle pulse.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mem_valid) begin
        mem_valid = 1'b0;
      end else if (stray_req) begin
        stray_req = 1'b0;
        mem_data  = mem[mem_addr];
        mem_valid = 1'b1;
      end else if (mem_rd === 1'b1) begin
        if (wait_cnt >= lat) begin
          mem_data  = mem[mem_addr];
          mem_valid = 1'b1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (op_valid) break;
    end
    chk(tag, 32'(op_valid), 32'd1);
  endtask

  task automatic wait_halted(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (halted) break;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_rd"},   32'(mem_rd),   32'd0);
    chk({tag, "_op_valid"}, 32'(op_valid), 32'd0);
    chk({tag, "_halted"},   32'(halted),   32'd0);
    chk({tag, "_addr"},     32'(mem_addr), 32'd0);
    chk({tag, "_fields"},   {21'd0, op, ra, rb, imm}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    do_reset();
    check_reset_outputs("rst");

    // 1: set r0,0x2A then halt
    mem[0] = 8'h40; mem[1] = 8'h2A; mem[2] = 8'h00;
    op_ready = 1'b1;
    pulse_start();
    wait_valid("t1_set_to", 20);
    chk("t1_set_bundle", {21'd0, op, ra, rb, imm}, {21'd0, 3'd2, 2'd0, 2'd0, 8'h2A});
    wait_valid("t1_halt_to", 20);
    chk("t1_halt_op", 32'(op), 32'd0);
    @(negedge clock);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_pc", 32'(mem_addr), 32'd3);
    chk("t1_mem_rd", 32'(mem_rd), 32'd0);
    pulse_start();
    @(negedge clock);
    chk("t1_start_ignored", {30'd0, halted, mem_rd}, 32'd2);

    // 2: copy r1,r2 held under backpressure
    do_reset();
    op_ready = 1'b0;
    mem[0] = 8'h6C; mem[1] = 8'h20; mem[2] = 8'h00;
    pulse_start();
    wait_valid("t2_copy_to", 20);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_bundle", {21'd0, op, ra, rb, imm}, {21'd0, 3'd3, 2'd1, 2'd2, 8'h00});
      chk("t2_stall_ctrl", {op_valid, mem_rd, 26'd0, mem_addr}, {1'b1, 1'b0, 26'd0, 4'd1});
      @(negedge clock);
    end
    op_ready = 1'b1;
    @(negedge clock);
    chk("t2_resume", {op_valid, mem_rd, 26'd0, mem_addr}, {1'b0, 1'b1, 26'd0, 4'd1});
    wait_halted("t2_halt_to", 30);
    chk("t2_pc", 32'(mem_addr), 32'd3);

    // 3: slow memory, request held steady
    do_reset();
    mem[0] = 8'h20; mem[1] = 8'h00;
    lat = 3;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold", {op_valid, mem_rd, 26'd0, mem_addr}, {1'b0, 1'b1, 26'd0, 4'd0});
      @(negedge clock);
    end
    wait_valid("t3_nop_to", 20);
    chk("t3_nop_op", 32'(op), 32'd1);
    lat = 0;

    // 4: pc wrap, 16 nops then halt at address 0
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h20;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (mem_rd && mem_addr == 4'd15) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_reach15", 32'(found), 32'd1);
    mem[0] = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_addr != 4'd15) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_wrap_addr", {31'd0, found} + 32'(mem_addr), 32'd1);
    wait_halted("t4_halt_to", 20);
    chk("t4_pc_after", 32'(mem_addr), 32'd1);

    // 5: reset during FETCH_IMM, then stray mem_valid
    do_reset();
    mem[0] = 8'hA0; mem[1] = 8'h05; mem[2] = 8'h00;
    lat = 3;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_rd && mem_addr == 4'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_in_fetch_imm", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("t5_mid_rst");
    reset = 1'b0;
    lat = 0;
    stray_req = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("t5_stray");

`ifdef ISSUE_COUNT_EN
    // 6: issue counter over addv/nop/halt
    do_reset();
    chk("t6_cnt_rst", 32'(issued_count), 32'd0);
    mem[0] = 8'hA0; mem[1] = 8'h05; mem[2] = 8'h20; mem[3] = 8'h00;
    op_ready = 1'b1;
    pulse_start();
    wait_halted("t6_halt_to", 40);
    chk("t6_cnt", 32'(issued_count), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
